uart_tx_scheduler: RTL and testbench

// - Shares the single uart_ip transmitter between N_REQ requesters; each requester supplies a byte and its own frame config.
// - Round-robin grant; reprograms the UART only when the config differs from the one loaded.
// - Sequence on reprogram: deactivate, write config, settle, reactivate. Then loads the byte and waits for the frame to finish.
// - Sits between client logic and the uart_ip config/transmit-data interface; one byte per grant.

---
 rtl/uart_ip_pkg.sv | 13 +
 rtl/uart_rr_arbiter.sv | 29 ++
 rtl/uart_tx_scheduler.sv | 136 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_ip_pkg.sv
// uart_ip_pkg: shared UART config type, scheduler state encoding and widths
package uart_ip_pkg;
    localparam int UART_CFG_W = 9;
    typedef struct packed {
        logic [3:0] baud;
        logic       stop;
        logic [1:0] parity;
        logic [1:0] frame;
    } uart_cfg_t;
    typedef enum logic [2:0] {
        IDLE, ARB, CFG_OFF, SETTLE, CFG_ON, LOAD, WAIT_RISE, WAIT_DONE
    } sched_state_t;
endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational round-robin pick, searching upward from start
module uart_rr_arbiter
    import uart_ip_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] start,
    input  logic                     en,
    output logic [N_REQ-1:0]         gnt_onehot,
    output logic [$clog2(N_REQ)-1:0] gnt_idx
);
    localparam int IW = $clog2(N_REQ);
    logic found;
    int idx;
    always_comb begin
        gnt_idx = '0;
        found = 1'b0;
        idx = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(start) + i) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                gnt_idx = IW'(idx);
            end
        end
        gnt_onehot = (en && found) ? N_REQ'(1) << gnt_idx : '0;
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART transmitter, reprogramming only on config change
module uart_tx_scheduler
    import uart_ip_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int SETTLE_CYCLES = 10,
    parameter int BUSY_TIMEOUT  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*8-1:0]          req_data,
    input  logic [N_REQ*UART_CFG_W-1:0] req_cfg,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            req_done,
    output logic [$clog2(N_REQ)-1:0]    grant_id,
    output logic                        uart_cfg_we,
    output uart_cfg_t                   uart_cfg,
    output logic                        uart_active,
    output logic                        uart_tx_we,
    output logic [7:0]                  uart_tx_data,
    input  logic                        uart_tx_busy,
    output logic                        err_timeout
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(SETTLE_CYCLES > BUSY_TIMEOUT ? SETTLE_CYCLES : BUSY_TIMEOUT) + 1;
    sched_state_t    state;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   ptr, gnt_idx;
    logic [N_REQ-1:0] gnt_onehot;
    logic            cfg_valid;
    uart_cfg_t       cap_cfg, loaded_cfg, win_cfg;
    logic [7:0]      cap_data, win_data;
    assign win_cfg  = uart_cfg_t'(req_cfg[UART_CFG_W*gnt_idx +: UART_CFG_W]);
    assign win_data = req_data[8*gnt_idx +: 8];
    uart_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req        (req_valid),
        .start      (ptr),
        .en         (state == ARB),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            ptr          <= '0;
            cfg_valid    <= 1'b0;
            cap_cfg      <= '0;
            loaded_cfg   <= '0;
            cap_data     <= '0;
            req_ready    <= '0;
            req_done     <= '0;
            grant_id     <= '0;
            uart_cfg_we  <= 1'b0;
            uart_cfg     <= '0;
            uart_active  <= 1'b0;
            uart_tx_we   <= 1'b0;
            uart_tx_data <= '0;
            err_timeout  <= 1'b0;
        end else begin
            uart_cfg_we <= 1'b0;
            uart_tx_we  <= 1'b0;
            req_ready   <= '0;
            req_done    <= '0;
            case (state)
                IDLE: if (|req_valid) state <= ARB;
                ARB: begin
                    if (!(|req_valid)) begin
                        state <= IDLE;
                    end else begin
                        cap_cfg  <= win_cfg;
                        cap_data <= win_data;
                        grant_id <= gnt_idx;
                        ptr      <= (gnt_idx == IW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
                        if (cfg_valid && win_cfg == loaded_cfg) begin
                            state        <= LOAD;
                            uart_tx_we   <= 1'b1;
                            uart_tx_data <= win_data;
                            req_ready    <= gnt_onehot;
                        end else begin
                            state       <= CFG_OFF;
                            uart_cfg_we <= 1'b1;
                            uart_cfg    <= win_cfg;
                            uart_active <= 1'b0;
                        end
                    end
                end
                CFG_OFF: begin
                    state <= SETTLE;
                    cnt   <= CW'(SETTLE_CYCLES-1);
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state       <= CFG_ON;
                        uart_cfg_we <= 1'b1;
                        uart_active <= 1'b1;
                        loaded_cfg  <= cap_cfg;
                        cfg_valid   <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CFG_ON: begin
                    state        <= LOAD;
                    uart_tx_we   <= 1'b1;
                    uart_tx_data <= cap_data;
                    req_ready    <= N_REQ'(1) << grant_id;
                end
                LOAD: begin
                    state <= WAIT_RISE;
                    cnt   <= '0;
                end
                WAIT_RISE: begin
                    if (uart_tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CW'(BUSY_TIMEOUT-1)) begin
                        state       <= IDLE;
                        err_timeout <= 1'b1;
                        cfg_valid   <= 1'b0;
                        req_done    <= N_REQ'(1) << grant_id;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_tx_busy) begin
                        state    <= IDLE;
                        req_done <= N_REQ'(1) << grant_id;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: scoreboard bench for the UART scheduler with a simple busy model
module tb_uart_tx_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [35:0] req_cfg = '0;
    logic [3:0]  req_ready, req_done;
    logic [1:0]  grant_id;
    logic        uart_cfg_we, uart_active, uart_tx_we, err_timeout;
    logic [8:0]  uart_cfg;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_busy = 1'b0;
    int checks = 0, errors = 0;
    typedef struct {int id; logic [7:0] d; logic [8:0] c; bit rp;} exp_t;
    exp_t exp_q[$];
    int   done_q[$];
    bit   dead = 1'b0;
    int   busy_len = 6;
    int   nwe = 0, cyc = 0, t0 = 0;

    uart_tx_scheduler dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_cfg(req_cfg),
        .req_ready(req_ready), .req_done(req_done), .grant_id(grant_id),
        .uart_cfg_we(uart_cfg_we), .uart_cfg(uart_cfg), .uart_active(uart_active),
        .uart_tx_we(uart_tx_we), .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   di;
        if (rst) begin
            nwe = 0;
        end else begin
            cyc++;
            if (uart_cfg_we) begin
                if (exp_q.size() == 0) begin
                    chk("cfg_we_unexpected", 1, 0);
                end else if (nwe == 0) begin
                    chk("cfg_off_active", uart_active, 0);
                    chk("cfg_off_cfg", uart_cfg, exp_q[0].c);
                    t0 = cyc;
                end else begin
                    chk("cfg_on_active", uart_active, 1);
                    chk("settle_gap", cyc - t0, 11);
                end
                nwe++;
            end
            if (uart_tx_we) begin
                if (exp_q.size() == 0) begin
                    chk("tx_we_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_data", uart_tx_data, e.d);
                    chk("tx_ready", req_ready, 32'd1 << e.id);
                    chk("tx_grant_id", grant_id, e.id);
                    chk("tx_cfg", uart_cfg, e.c);
                    chk("tx_active", uart_active, 1);
                    chk("cfg_we_count", nwe, e.rp ? 2 : 0);
                end
                nwe = 0;
            end
            if (req_done != '0) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", req_done, 0);
                end else begin
                    di = done_q.pop_front();
                    chk("done_id", req_done, 32'd1 << di);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (uart_tx_we && !dead) begin
                uart_tx_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                uart_tx_busy = 1'b0;
            end
        end
    end

    task automatic wait_done();
        int k = 0;
        while (done_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("done_within_bound", done_q.size(), 0);
    endtask

    task automatic send(int id, logic [7:0] d, logic [8:0] c, bit rp, int lat, bit wd);
        int  n = 0;
        bit  got = 1'b0;
        exp_t e;
        e.id = id; e.d = d; e.c = c; e.rp = rp;
        exp_q.push_back(e);
        done_q.push_back(id);
        req_data[8*id +: 8] = d;
        req_cfg[9*id +: 9] = c;
        req_valid[id] = 1'b1;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            n++;
            if (req_ready[id]) got = 1'b1;
        end
        chk("ready_latency", got ? n : -1, lat);
        req_valid[id] = 1'b0;
        if (wd) wait_done();
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_done"}, req_done, 0);
        chk({tag, "_grant"}, grant_id, 0);
        chk({tag, "_cfg_we"}, uart_cfg_we, 0);
        chk({tag, "_cfg"}, uart_cfg, 0);
        chk({tag, "_active"}, uart_active, 0);
        chk({tag, "_tx_we"}, uart_tx_we, 0);
        chk({tag, "_tx_data"}, uart_tx_data, 0);
        chk({tag, "_err"}, err_timeout, 0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        send(0, 8'hA5, 9'h0E1, 1'b1, 14, 1'b1);
        send(0, 8'h3C, 9'h0E1, 1'b0, 2, 1'b1);
        send(1, 8'h11, 9'h123, 1'b1, 14, 1'b1);
        send(2, 8'h22, 9'h0A5, 1'b1, 14, 1'b1);
        send(1, 8'h33, 9'h123, 1'b1, 14, 1'b1);
        send(2, 8'h44, 9'h0A5, 1'b1, 14, 1'b1);

        pulse_rst();
        begin
            logic [7:0] bytes [5] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54};
            int ids [5] = '{0, 1, 2, 3, 0};
            exp_t e;
            bit got;
            req_data = {8'h53, 8'h52, 8'h51, 8'h50};
            req_cfg = {4{9'h0E1}};
            for (int k = 0; k < 5; k++) begin
                e.id = ids[k]; e.d = bytes[k]; e.c = 9'h0E1; e.rp = (k == 0);
                exp_q.push_back(e);
                done_q.push_back(ids[k]);
            end
            req_valid = 4'hF;
            for (int k = 0; k < 5; k++) begin
                got = 1'b0;
                for (int j = 0; j < 400 && !got; j++) begin
                    @(negedge clk);
                    if (req_ready != '0) got = 1'b1;
                end
                chk("rr_ready_seen", got, 1);
                if (k == 0 && req_ready == 4'b0001) req_data[7:0] = 8'h54;
                else req_valid = req_valid & ~req_ready;
            end
            req_valid = '0;
            wait_done();
        end

        chk("err_before_timeout", err_timeout, 0);
        dead = 1'b1;
        send(3, 8'h77, 9'h0E1, 1'b0, 2, 1'b1);
        chk("err_after_timeout", err_timeout, 1);
        dead = 1'b0;
        send(3, 8'h78, 9'h0E1, 1'b1, 14, 1'b1);
        chk("err_sticky", err_timeout, 1);

        busy_len = 8;
        send(0, 8'h99, 9'h0E1, 1'b0, 2, 1'b0);
        repeat (3) @(negedge clk);
        chk("busy_before_rst", uart_tx_busy, 1);
        rst = 1'b1;
        done_q.delete();
        @(negedge clk);
        check_zero("mid_rst");
        rst = 1'b0;
        send(0, 8'h9A, 9'h0E1, 1'b1, 14, 1'b1);
        chk("exp_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end
endmodule
